branch_predictor_gen2: RTL and testbench



---
 rtl/branch_predictor_gen2.sv | 153 +++++++++++++++
 tb/tb_branch_predictor_gen2.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gen2.sv
// IF-stage branch predictor: gshare direction (2-bit counters), tagged direct-mapped BTB,
// optional return address stack enabled by defining BP_RAS_EN.
module branch_predictor_gen2 #(
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned PHT_IDX_W = 6,
  parameter int unsigned GHR_W     = 6,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_if,
  input  logic [31:0] pc_if,
  input  logic        if_valid,
  input  logic [31:0] pc_id,
  input  logic [31:0] real_bjpc,
  input  logic        ud_BTB,
  input  logic        ud_pdt,
  input  logic        real_br_taken,
  output logic        pre_taken,
  output logic        sel_bj_pc,
  output logic [31:0] pre_bjpc
);

  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam int unsigned PHT_N = 1 << PHT_IDX_W;
  localparam int unsigned TAG_W = 30 - BTB_IDX_W;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_j, is_jal, is_jr, is_br, is_bj;

  assign op     = inst_if[31:26];
  assign funct  = inst_if[5:0];
  assign is_j   = (op == 6'b000010);
  assign is_jal = (op == 6'b000011);
  assign is_jr  = (op == 6'b000000) && (funct == 6'b001000);
  assign is_br  = (op == 6'b000100) || (op == 6'b000101);
  assign is_bj  = is_j | is_jal | is_jr | is_br;

  // BTB: only the valid bits need reset; tag/target are qualified by valid.
  logic [BTB_N-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [31:0]      btb_tgt [BTB_N];
  logic [BTB_IDX_W-1:0] btb_ridx, btb_widx;
  logic                 btb_hit;

  assign btb_ridx = pc_if[BTB_IDX_W+1:2];
  assign btb_widx = pc_id[BTB_IDX_W+1:2];
  assign btb_hit  = is_bj && btb_valid[btb_ridx] && (btb_tag[btb_ridx] == pc_if[31:BTB_IDX_W+2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      btb_valid <= '0;
    else if (ud_BTB)
      btb_valid[btb_widx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ud_BTB) begin
      btb_tag[btb_widx] <= pc_id[31:BTB_IDX_W+2];
      btb_tgt[btb_widx] <= real_bjpc;
    end
  end

  logic [1:0]           pht [PHT_N];
  logic [GHR_W-1:0]     ghr;
  logic [PHT_IDX_W-1:0] pht_ridx, pht_widx;

  assign pht_ridx  = pc_if[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign pht_widx  = pc_id[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign pre_taken = pht[pht_ridx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
      for (int unsigned i = 0; i < PHT_N; i++)
        pht[i] <= 2'b01;
    end else if (ud_pdt) begin
      if (real_br_taken) begin
        if (pht[pht_widx] != 2'b11)
          pht[pht_widx] <= pht[pht_widx] + 2'b01;
      end else if (pht[pht_widx] != 2'b00) begin
        pht[pht_widx] <= pht[pht_widx] - 2'b01;
      end
      ghr <= (ghr << 1) | GHR_W'(real_br_taken);
    end
  end

  logic        ras_hit;
  logic [31:0] ras_top;

`ifdef BP_RAS_EN
  localparam int unsigned SP_W  = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = SP_W + 1;

  logic [31:0]      ras [RAS_DEPTH];
  logic [SP_W-1:0]  ras_sp;
  logic [SP_W-1:0]  ras_top_idx;
  logic [CNT_W-1:0] ras_cnt;
  logic             is_jr_ra, ras_empty, ras_full, ras_push, ras_pop;
  logic             unused_bits;

  // ras_sp is the next write slot; when full it already points at the oldest entry.
  assign is_jr_ra    = is_jr && (inst_if[25:21] == 5'd31);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_push    = if_valid && is_jal;
  assign ras_pop     = if_valid && is_jr_ra && !ras_empty;
  assign ras_top_idx = ras_sp - SP_W'(1);
  assign ras_top     = ras[ras_top_idx];
  assign ras_hit     = is_jr_ra && !ras_empty;
  assign unused_bits = ^{inst_if[20:6], pc_id[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_sp <= ras_sp + SP_W'(1);
      if (!ras_full)
        ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_pop) begin
      ras_sp  <= ras_top_idx;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push)
      ras[ras_sp] <= pc_if + 32'd4;
  end
`else
  logic unused_bits;

  assign ras_hit     = 1'b0;
  assign ras_top     = '0;
  assign unused_bits = ^{if_valid, inst_if[25:6], pc_if[1:0], pc_id[1:0]};
`endif

  always_comb begin
    sel_bj_pc = 1'b0;
    pre_bjpc  = btb_tgt[btb_ridx];
    if (ras_hit) begin
      sel_bj_pc = 1'b1;
      pre_bjpc  = ras_top;
    end else if (is_j || is_jal || is_jr) begin
      sel_bj_pc = btb_hit;
    end else if (is_br) begin
      sel_bj_pc = btb_hit && pre_taken;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gen2.sv
// Randomised self-checking bench for branch_predictor_gen2 against a behavioural model
// (BTB/PHT as arrays indexed by PC, RAS as a bounded queue).
module tb_branch_predictor_gen2;

  localparam int unsigned BTB_IDX_W = 4;
  localparam int unsigned PHT_IDX_W = 6;
  localparam int unsigned GHR_W     = 6;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned BTB_N     = 1 << BTB_IDX_W;
  localparam int unsigned PHT_N     = 1 << PHT_IDX_W;
`ifdef BP_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  // instruction kinds: 0 j, 1 jal, 2 jr (rs!=31), 3 jr $31, 4 beq, 5 bne, 6 other
  localparam int K_J = 0, K_JAL = 1, K_JR = 2, K_JRRA = 3, K_BEQ = 4, K_BNE = 5, K_OTH = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_if, pc_if, pc_id, real_bjpc, pre_bjpc;
  logic        if_valid, ud_BTB, ud_pdt, real_br_taken, pre_taken, sel_bj_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_kind;

  bit          m_valid [BTB_N];
  logic [31:0] m_tagpc [BTB_N];
  logic [31:0] m_tgt   [BTB_N];
  int unsigned m_cnt   [PHT_N];
  int unsigned m_ghr;
  logic [31:0] m_ras[$];

  branch_predictor_gen2 #(
    .BTB_IDX_W(BTB_IDX_W),
    .PHT_IDX_W(PHT_IDX_W),
    .GHR_W    (GHR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_if      (inst_if),
    .pc_if        (pc_if),
    .if_valid     (if_valid),
    .pc_id        (pc_id),
    .real_bjpc    (real_bjpc),
    .ud_BTB       (ud_BTB),
    .ud_pdt       (ud_pdt),
    .real_br_taken(real_br_taken),
    .pre_taken    (pre_taken),
    .sel_bj_pc    (sel_bj_pc),
    .pre_bjpc     (pre_bjpc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] make_inst(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_J:    return {6'b000010, r[25:0]};
      K_JAL:  return {6'b000011, r[25:0]};
      K_JR:   return {6'b000000, 5'($urandom_range(0, 30)), r[20:6], 6'b001000};
      K_JRRA: return {6'b000000, 5'd31, r[20:6], 6'b001000};
      K_BEQ:  return {6'b000100, r[25:0]};
      K_BNE:  return {6'b000101, r[25:0]};
      default: begin
        case (r[1:0])
          2'd0:    return {6'b001000, r[25:0]};                     // addi
          2'd1:    return {6'b000000, 5'd31, r[20:6], 6'b100000};   // add with rs=31
          2'd2:    return {6'b000000, 5'd31, r[20:6], 6'b001001};   // jalr $31
          default: return {6'b100011, r[25:0]};                     // lw
        endcase
      end
    endcase
  endfunction

  function automatic int unsigned bidx(input logic [31:0] pc);
    return int'((pc >> 2) % BTB_N);
  endfunction

  function automatic int unsigned pidx(input logic [31:0] pc);
    return int'(((pc >> 2) ^ m_ghr) % PHT_N);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BTB_N; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < PHT_N; i++) m_cnt[i] = 1;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  task automatic model_check();
    int unsigned bi;
    bit exp_pt, hit, exp_sel;
    logic [31:0] exp_pc;
    bi      = bidx(pc_if);
    exp_pt  = (m_cnt[pidx(pc_if)] >= 2);
    hit     = (cur_kind <= K_BNE) && m_valid[bi] &&
              ((m_tagpc[bi] >> (BTB_IDX_W + 2)) == (pc_if >> (BTB_IDX_W + 2)));
    exp_pc  = m_tgt[bi];
    if (RAS_ON && cur_kind == K_JRRA && m_ras.size() > 0) begin
      exp_sel = 1'b1;
      exp_pc  = m_ras[$];
    end else if (cur_kind <= K_JRRA) exp_sel = hit;
    else if (cur_kind <= K_BNE)      exp_sel = hit && exp_pt;
    else                             exp_sel = 1'b0;
    check_eq("pre_taken", 32'(pre_taken), 32'(exp_pt));
    check_eq("sel_bj_pc", 32'(sel_bj_pc), 32'(exp_sel));
    if (exp_sel) check_eq("pre_bjpc", pre_bjpc, exp_pc);
  endtask

  function automatic void model_update();
    int unsigned bi, pi;
    if (ud_BTB) begin
      bi = bidx(pc_id);
      m_valid[bi] = 1'b1;
      m_tagpc[bi] = pc_id;
      m_tgt[bi]   = real_bjpc;
    end
    if (ud_pdt) begin
      pi = pidx(pc_id);
      if (real_br_taken && m_cnt[pi] < 3) m_cnt[pi]++;
      else if (!real_br_taken && m_cnt[pi] > 0) m_cnt[pi]--;
      m_ghr = ((m_ghr << 1) | 32'(real_br_taken)) % (1 << GHR_W);
    end
    if (RAS_ON && if_valid) begin
      if (cur_kind == K_JAL) begin
        m_ras.push_back(pc_if + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (cur_kind == K_JRRA && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endfunction

  // Called just after a falling edge: drive, let logic settle, compare with the model.
  task automatic apply(input int kind, input logic [31:0] pc, input logic iv,
                       input logic [31:0] pid, input logic [31:0] tgt,
                       input logic ub, input logic up, input logic tk);
    cur_kind      = kind;
    inst_if       = make_inst(kind);
    pc_if         = pc;
    if_valid      = iv;
    pc_id         = pid;
    real_bjpc     = tgt;
    ud_BTB        = ub;
    ud_pdt        = up;
    real_br_taken = tk;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    apply(K_BEQ, 32'h0040_0010, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_sel", 32'(sel_bj_pc), 32'd0);
    check_eq("rst_taken", 32'(pre_taken), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    apply(K_BEQ, 32'h0040_0010, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cold_beq_taken", 32'(pre_taken), 32'd0);
    check_eq("cold_beq_sel", 32'(sel_bj_pc), 32'd0);
    tick();

    // Eight taken trainings: the first six walk the GHR to all-ones, the last two hit one counter.
    for (int i = 0; i < 8; i++) begin
      apply(K_OTH, 32'h0040_0000, 1'b1, 32'h0040_0010, 32'h0040_0100, i == 0, 1'b1, 1'b1);
      tick();
    end
    apply(K_BEQ, 32'h0040_0010, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("trained_taken", 32'(pre_taken), 32'd1);
    check_eq("trained_sel", 32'(sel_bj_pc), 32'd1);
    check_eq("trained_tgt", pre_bjpc, 32'h0040_0100);
    tick();

    apply(K_J, 32'h0040_0050, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("alias_sel", 32'(sel_bj_pc), 32'd0);
    tick();
    apply(K_J, 32'h0040_0010, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("j_hit_sel", 32'(sel_bj_pc), 32'd1);
    tick();

    for (int i = 0; i < 3; i++) begin
      apply(K_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0010, '0, 1'b0, 1'b1, 1'b1);
      check_eq("sat_taken", 32'(pre_taken), 32'd1);
      tick();
    end
    apply(K_BEQ, 32'h0040_0010, 1'b1, 32'h0040_0010, '0, 1'b0, 1'b1, 1'b0);
    check_eq("sat_top", 32'(pre_taken), 32'd1);
    tick();
    // GHR is now 62, so pc 0x..14 maps onto the same counter (now 10).
    apply(K_BEQ, 32'h0040_0014, 1'b1, 32'h0040_0014, '0, 1'b0, 1'b1, 1'b0);
    check_eq("sat_minus1", 32'(pre_taken), 32'd1);
    check_eq("sat_minus1_sel", 32'(sel_bj_pc), 32'd0);
    tick();
    apply(K_BEQ, 32'h0040_001C, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_minus2", 32'(pre_taken), 32'd0);
    tick();

    apply(K_J, 32'h0040_0010, 1'b1, 32'h0040_0010, 32'h0040_0200, 1'b1, 1'b0, 1'b0);
    check_eq("rdw_old_tgt", pre_bjpc, 32'h0040_0100);
    tick();
    apply(K_J, 32'h0040_0010, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("rdw_new_tgt", pre_bjpc, 32'h0040_0200);
    tick();

    do_reset();
    for (int k = 1; k <= 5; k++) begin
      apply(K_JAL, 32'(k * 32'h100), 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 5; k >= 1; k--) begin
      apply(K_JRRA, 32'h0040_0300, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
      if (RAS_ON) begin
        check_eq("ras_pop_sel", 32'(sel_bj_pc), 32'(k > 1));
        if (k > 1) check_eq("ras_pop_top", pre_bjpc, 32'(k * 32'h100 + 32'h4));
      end
      tick();
    end

    apply(K_JAL, 32'hFFFF_FFFC, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(K_JAL, 32'h0000_0600, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(K_JRRA, 32'h0040_0300, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(K_JRRA, 32'h0040_0300, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    if (RAS_ON) check_eq("ras_wrap_top", pre_bjpc, 32'h0000_0000);
    tick();
    apply(K_JRRA, 32'h0040_0300, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("ras_novalid_sel", 32'(sel_bj_pc), 32'd0);
    tick();

    apply(K_JAL, 32'h0000_0700, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    apply(K_JRRA, 32'h0040_0300, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("ras_after_rst_sel", 32'(sel_bj_pc), 32'd0);
    tick();

    for (int n = 0; n < 800; n++) begin
      logic [31:0] pc, pid;
      if ($urandom_range(0, 149) == 0) do_reset();
      pc  = 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
      pid = 32'h0040_0000 + (32'($urandom_range(0, 127)) << 2);
      apply($urandom_range(0, 6), pc, 1'($urandom_range(0, 1)), pid, $urandom,
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
